any1_issue_sched: RTL
=====================

// Module: any1_issue_sched
// PURPOSE
//  Issue controller between any1_decode and the execute stage. Captures one decoded packet into a
//  holding register, checks it against a scalar-register scoreboard and a busy timer for the long
//  (mul/div) unit, and releases it to execute only when its operands and unit are free.
//  Sets scoreboard bits on issue; writeback clears them.
// PARAMETERS
//  PW        64  width of the opaque decoded payload carried with the packet
//  NREG      64  number of scalar registers tracked (register index width 6)
//  LONG_LAT  8   cycles the long unit stays busy after a long op issues (range 1..15)
// PORTS
//  clk_i         in   1     clock
//  rst_i         in   1     synchronous reset, active high
//  flush_i       in   1     discard the held packet (branch mispredict or exception)
//  dec_valid_i   in   1     decode offers a packet
//  dec_ready_o   out  1     scheduler accepts the offered packet this cycle
//  dec_pay_i     in   PW    opaque decoded payload
//  dec_Ra_i      in   6     source A register
//  dec_Rb_i      in   6     source B register
//  dec_Rc_i      in   6     source C register
//  dec_needRc_i  in   1     source C is a true operand
//  dec_Rt_i      in   6     destination register
//  dec_rfwr_i    in   1     packet writes Rt
//  dec_long_i    in   1     packet uses the long (mul/div) unit
//  dec_ui_i      in   1     unimplemented instruction
//  wb_valid_i    in   1     writeback retiring a register this cycle
//  wb_Rt_i       in   6     register being written back
//  iss_valid_o   out  1     packet presented to execute
//  iss_ready_i   in   1     execute takes the packet
//  iss_pay_o     out  PW    held payload
//  iss_exc_o     out  1     presented packet is unimplemented (raises an exception; no reg write)
//  stall_o       out  1     packet held and blocked by a hazard
// BEHAVIOUR
//  - Reset: state EMPTY; scoreboard all 0; busy timer 0; all outputs 0 except dec_ready_o=1.
//  - States: EMPTY (no packet), HOLD (packet blocked), OFFER (iss_valid_o=1).
//  - dec_ready_o = (state==EMPTY) | (state==OFFER & iss_ready_i); same-cycle refill is allowed.
//  - Accept (dec_valid_i & dec_ready_o): latch all dec_* into the holding register; next state is
//    OFFER if hz==0 on the new packet (evaluated combinationally on dec_* inputs), otherwise HOLD.
//  - Hazard term hz = sb[Ra] | sb[Rb] | (needRc & sb[Rc]) | (long & busy!=0). Register 0 never
//    hazards. A writeback clearing reg r in cycle t makes r ready in cycle t (bypass).
//  - HOLD -> OFFER when hz==0. OFFER is never revoked: iss_valid_o and the payload stay stable until
//    iss_ready_i.
//  - Issue (iss_valid_o & iss_ready_i): if rfwr & !ui & Rt!=0, set sb[Rt]. If long & !ui, load
//    busy=LONG_LAT. Otherwise busy decrements to 0 each cycle.
//  - Set and clear of the same reg in the same cycle: the set wins (the new writer is pending).
//  - iss_exc_o = held ui while OFFER. An ui packet skips the scoreboard and busy check (hz forced 0).
//  - flush_i: the next state is EMPTY, dec_ready_o=0 that cycle, and the held packet is dropped even
//    if iss_ready_i is high. The scoreboard and busy timer are untouched, because in-flight ops still
//    write back. Flush wins over accept and issue.
//  - stall_o = (state==HOLD).
//  - A writeback to a reg whose sb bit is 0 is ignored.
//  - Reset mid-operation discards the packet and clears the scoreboard.
// TESTING
//  - Back-to-back independent ADDs (Rt=3, Rt=4), iss_ready_i=1 -> one issue per cycle; sb[3], sb[4]
//    set.
//  - ADD Rt=5, then Ra=5 with no wb -> HOLD, stall_o=1. wb_valid_i=1, wb_Rt_i=5 -> iss_valid_o=1
//    that same cycle.
//  - DIV (long), then MUL (long), LONG_LAT=8 -> MUL issues exactly 8 cycles after DIV.
//  - iss_ready_i=0 for 3 cycles -> iss_pay_o is stable, dec_ready_o=0, nothing is lost.
//  - flush_i during HOLD -> EMPTY next cycle; no issue; sb is unchanged.
//  - Issue Rt=7 while wb_Rt_i=7 in the same cycle -> sb[7]=1. Also: ui packet -> iss_exc_o=1 and sb
//    is unchanged.

Source files
------------

// File: rtl/any1_issue_sched.sv
// any1_issue_sched: single-entry issue stage between any1_decode and execute.
// Holds one packet until its source registers and the long (mul/div) unit are free.

module any1_sb_cell (
  input  logic clk_i,
  input  logic rst_i,
  input  logic set_i,
  input  logic clr_i,
  output logic q_o,
  output logic byp_o
);
  logic bit_q, bit_d;

  // A new writer pending on this register outranks a retiring older one.
  always_comb begin
    bit_d = bit_q;
    if (clr_i) bit_d = 1'b0;
    if (set_i) bit_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) bit_q <= 1'b0;
    else       bit_q <= bit_d;
  end

  assign q_o   = bit_q;
  assign byp_o = bit_q & ~clr_i;
endmodule

module any1_issue_sched #(
  parameter int PW       = 64,
  parameter int NREG     = 64,
  parameter int LONG_LAT = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          dec_valid_i,
  output logic          dec_ready_o,
  input  logic [PW-1:0] dec_pay_i,
  input  logic [5:0]    dec_Ra_i,
  input  logic [5:0]    dec_Rb_i,
  input  logic [5:0]    dec_Rc_i,
  input  logic          dec_needRc_i,
  input  logic [5:0]    dec_Rt_i,
  input  logic          dec_rfwr_i,
  input  logic          dec_long_i,
  input  logic          dec_ui_i,
  input  logic          wb_valid_i,
  input  logic [5:0]    wb_Rt_i,
  output logic          iss_valid_o,
  input  logic          iss_ready_i,
  output logic [PW-1:0] iss_pay_o,
  output logic          iss_exc_o,
  output logic          stall_o
);
  typedef struct packed {
    logic [PW-1:0] pay;
    logic [5:0]    ra;
    logic [5:0]    rb;
    logic [5:0]    rc;
    logic [5:0]    rt;
    logic          need_rc;
    logic          rfwr;
    logic          lng;
    logic          ui;
  } pkt_t;

  typedef enum logic [1:0] {S_EMPTY, S_HOLD, S_OFFER} state_e;

  // busy_q counts the cycles the unit stays blocked after the current one.
  localparam logic [3:0] LAT_M1 = 4'(LONG_LAT - 1);

  state_e          state_q, state_d;
  pkt_t            held_q, dec_pkt;
  logic [3:0]      busy_q, busy_d;
  logic [NREG-1:0] sb_q, sb_byp, sb_fwd, sb_set, sb_clr;
  logic            hz_hold, hz_acc, acc, fire, long_fire, issue_wr;

  function automatic logic hazard(input pkt_t p, input logic [NREG-1:0] sb,
                                  input logic unit_busy);
    hazard = !p.ui & (sb[p.ra] | sb[p.rb] | (p.need_rc & sb[p.rc]) | (p.lng & unit_busy));
  endfunction

  assign dec_pkt = '{pay: dec_pay_i, ra: dec_Ra_i, rb: dec_Rb_i, rc: dec_Rc_i, rt: dec_Rt_i,
                     need_rc: dec_needRc_i, rfwr: dec_rfwr_i, lng: dec_long_i, ui: dec_ui_i};

  for (genvar r = 0; r < NREG; r++) begin : g_sb
    any1_sb_cell u_cell (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .set_i (sb_set[r]),
      .clr_i (sb_clr[r]),
      .q_o   (sb_q[r]),
      .byp_o (sb_byp[r])
    );
  end

  // Held packet sees only this cycle's writebacks; the packet being accepted also
  // sees the destination of the packet leaving in the same cycle.
  assign hz_hold = hazard(held_q, sb_byp, busy_q != 4'd0);
  assign sb_fwd  = sb_byp | sb_set;
  assign hz_acc  = hazard(dec_pkt, sb_fwd, long_fire | (busy_q != 4'd0));

  assign iss_valid_o = !flush_i & ((state_q == S_OFFER) | ((state_q == S_HOLD) & !hz_hold));
  assign fire        = iss_valid_o & iss_ready_i;
  assign long_fire   = fire & held_q.lng & !held_q.ui;
  assign issue_wr    = fire & held_q.rfwr & !held_q.ui & (held_q.rt != 6'd0);
  assign sb_set      = issue_wr   ? (NREG'(1) << held_q.rt) : '0;
  assign sb_clr      = wb_valid_i ? (NREG'(1) << wb_Rt_i)   : '0;

  assign dec_ready_o = !flush_i & ((state_q == S_EMPTY) | ((state_q == S_OFFER) & iss_ready_i));
  assign acc         = dec_valid_i & dec_ready_o;

  assign iss_pay_o = held_q.pay;
  assign iss_exc_o = iss_valid_o & held_q.ui;
  assign stall_o   = (state_q == S_HOLD);

  always_comb begin
    state_d = state_q;
    if (flush_i)                               state_d = S_EMPTY;
    else if (acc)                              state_d = hz_acc ? S_HOLD : S_OFFER;
    else if (fire)                             state_d = S_EMPTY;
    else if ((state_q == S_HOLD) && !hz_hold)  state_d = S_OFFER;
  end

  always_comb begin
    busy_d = (busy_q != 4'd0) ? busy_q - 4'd1 : 4'd0;
    if (long_fire) busy_d = LAT_M1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_EMPTY;
      busy_q  <= 4'd0;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      if (acc) held_q <= dec_pkt;
    end
  end
endmodule
